// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: backend control, I$ request/response, and the decode-side queue head.
// The master modport is the fetch unit; the slave modport is its environment.
interface fetch_unit_if #(
    parameter int QUEUE_DEPTH = 4
);
    logic                            fetch_en;
    logic                            redirect_valid;
    logic [63:0]                     redirect_pc;
    logic [63:0]                     ic_req_addr;
    logic [31:0]                     ic_resp_inst;
    logic                            ic_resp_valid;
    logic                            dec_valid;
    logic [31:0]                     dec_inst;
    logic [63:0]                     dec_pc;
    logic                            dec_ready;
    logic [$clog2(QUEUE_DEPTH):0]    q_count;

    modport master (
        input  fetch_en, redirect_valid, redirect_pc, ic_resp_inst, ic_resp_valid, dec_ready,
        output ic_req_addr, dec_valid, dec_inst, dec_pc, q_count
    );

    modport slave (
        output fetch_en, redirect_valid, redirect_pc, ic_resp_inst, ic_resp_valid, dec_ready,
        input  ic_req_addr, dec_valid, dec_inst, dec_pc, q_count
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: sequential PC, single-port I$ handshake and a circular instruction queue.
// Redirects flush the queue and reload the PC, taking priority over everything else.
module fetch_unit #(
    parameter int          QUEUE_DEPTH = 4,
    parameter logic [63:0] RESET_PC    = 64'h0
) (
    input  logic          clk,
    input  logic          reset,
    fetch_unit_if.master  bus
);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [63:0] RESET_PC_ALIGNED = {RESET_PC[63:2], 2'b00};

    logic [63:0]      pc_q, pc_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [63:0]      mem_pc_q   [QUEUE_DEPTH];
    logic [31:0]      mem_inst_q [QUEUE_DEPTH];

    logic             full;
    logic             dec_valid;
    logic             pop;
    logic             accept;
    logic             unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

    assign full      = (count_q == CNT_W'(QUEUE_DEPTH));
    assign dec_valid = (count_q != '0);
    assign pop       = dec_valid && bus.dec_ready;
    // A pop in the same cycle frees the slot, so a full queue can still accept.
    assign accept    = bus.fetch_en && bus.ic_resp_valid && (!full || pop) && !bus.redirect_valid;

    always_comb begin
        pc_d    = pc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (bus.redirect_valid) begin
            pc_d    = {bus.redirect_pc[63:2], 2'b00};
            head_d  = tail_q;
            count_d = '0;
        end else begin
            if (accept) begin
                pc_d   = pc_q + 64'd4;
                tail_d = tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(accept) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q    <= RESET_PC_ALIGNED;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            pc_q    <= pc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible once count covers them.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_pc_q[tail_q]   <= pc_q;
            mem_inst_q[tail_q] <= bus.ic_resp_inst;
        end
    end

    assign bus.ic_req_addr = pc_q;
    assign bus.q_count     = count_q;
    assign bus.dec_valid   = dec_valid;
    assign bus.dec_pc      = dec_valid ? mem_pc_q[head_q]   : 64'h0;
    assign bus.dec_inst    = dec_valid ? mem_inst_q[head_q] : 32'h0;
endmodule
